// File: rtl/block_words_pkg.sv
// Shared widths and types for the word/block packer and unpacker pair.
package block_words_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned BLOCK_W = WORD_W * WORDS;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

endpackage

// File: rtl/block_words.sv
// Unpacks one WORD_W*WORDS block into WORDS words, most significant word first,
// with valid/ready on both sides and no bubble between consecutive blocks.
module block_words
  import block_words_pkg::*;
#(
  parameter int unsigned WORD_W = block_words_pkg::WORD_W,
  parameter int unsigned WORDS  = block_words_pkg::WORDS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      block_valid,
  output logic                      block_ready,
  input  logic [WORD_W*WORDS-1:0]   block,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic [WORD_W-1:0]         word,
  output logic                      word_last
);

  localparam int unsigned BW    = WORD_W * WORDS;
  localparam int unsigned CNT_W = $clog2(WORDS + 1);

  logic [BW-1:0]    sreg;
  logic [CNT_W-1:0] cnt;
  logic             wt;
  logic             bt;

  assign word_valid = (cnt != '0);
  assign word_last  = (cnt == CNT_W'(1));
  assign word       = sreg[BW-1 -: WORD_W];

  // Refill is allowed while the final word leaves, which is what keeps
  // back-to-back blocks gap-free; word_ready is the only input feeding this.
  assign block_ready = (cnt == '0) || ((cnt == CNT_W'(1)) && word_ready);

  assign wt = word_valid & word_ready;
  assign bt = block_valid & block_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (bt) begin
      sreg <= block;
      cnt  <= CNT_W'(WORDS);
    end else if (wt) begin
      sreg <= sreg << WORD_W;
      cnt  <= cnt - CNT_W'(1);
    end
  end

endmodule
